// File: rtl/ila_capture_ctrl_pkg.sv
// Shared definitions for the ILA capture sequencer: state encodings used by the
// RTL, the register file and the software header.
package ila_capture_ctrl_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        StIdle  = 3'd0,
        StPre   = 3'd1,
        StArmed = 3'd2,
        StPost  = 3'd3,
        StDone  = 3'd4
    } cap_state_e;

endpackage

// File: rtl/ila_capture_ptr.sv
// Circular write pointer with saturating fill count; start_addr points at the
// oldest valid sample in the buffer.
module ila_capture_ptr #(
    parameter int unsigned BUFFER_W = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                inc,
    output logic [BUFFER_W-1:0] wr_ptr,
    output logic [BUFFER_W:0]   fill,
    output logic [BUFFER_W-1:0] start_addr
);

    localparam logic [BUFFER_W:0] DEPTH = {1'b1, {BUFFER_W{1'b0}}};

    logic [BUFFER_W-1:0] ptr_d, ptr_q;
    logic [BUFFER_W:0]   fill_d, fill_q;
    logic [BUFFER_W-1:0] start_d, start_q;

    always_comb begin
        ptr_d  = ptr_q;
        fill_d = fill_q;
        if (clr) begin
            ptr_d  = '0;
            fill_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + 1'b1;
            if (fill_q != DEPTH) begin
                fill_d = fill_q + 1'b1;
            end
        end
        // A full buffer drops the MSB, so start lands on wr_ptr (oldest = next overwritten).
        start_d = ptr_d - fill_d[BUFFER_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            fill_q  <= '0;
            start_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            fill_q  <= fill_d;
            start_q <= start_d;
        end
    end

    assign wr_ptr     = ptr_q;
    assign fill       = fill_q;
    assign start_addr = start_q;

endmodule

// File: rtl/ila_capture_ctrl.sv
// ILA capture sequencer: pre-trigger fill, trigger detection, post-trigger
// countdown; drives the sample buffer write port.
module ila_capture_ctrl
    import ila_capture_ctrl_pkg::*;
#(
    parameter int unsigned BUFFER_W = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rst_soft,
    input  logic                arm,
    input  logic [BUFFER_W-1:0] pre_count,
    input  logic [BUFFER_W-1:0] post_count,
    input  logic                sample_valid,
    input  logic                trigger_hit,
    output logic                wr_en,
    output logic [BUFFER_W-1:0] wr_addr,
    output logic [BUFFER_W-1:0] trigger_addr,
    output logic [BUFFER_W-1:0] start_addr,
    output logic [BUFFER_W:0]   samples,
    output logic                busy,
    output logic                done,
    output logic [STATE_W-1:0]  state
);

    cap_state_e          state_d, state_q;
    logic [BUFFER_W-1:0] pre_d, pre_q, post_d, post_q;
    logic [BUFFER_W-1:0] post_cnt_d, post_cnt_q;
    logic [BUFFER_W-1:0] trig_d, trig_q;
    logic [BUFFER_W-1:0] wr_ptr;
    logic [BUFFER_W:0]   fill, fill_inc, post_cnt_inc;
    logic                capturing;

    assign capturing = (state_q == StPre) || (state_q == StArmed) || (state_q == StPost);
    // A sample coinciding with arm or soft reset belongs to neither capture.
    assign wr_en     = sample_valid & capturing & ~arm & ~rst_soft;

    ila_capture_ptr #(
        .BUFFER_W (BUFFER_W)
    ) u_ptr (
        .clk        (clk),
        .rst        (rst),
        .clr        (rst_soft | arm),
        .inc        (wr_en),
        .wr_ptr     (wr_ptr),
        .fill       (fill),
        .start_addr (start_addr)
    );

    assign fill_inc     = fill + 1'b1;
    assign post_cnt_inc = {1'b0, post_cnt_q} + 1'b1;

    always_comb begin
        state_d    = state_q;
        pre_d      = pre_q;
        post_d     = post_q;
        post_cnt_d = post_cnt_q;
        trig_d     = trig_q;
        if (rst_soft) begin
            state_d    = StIdle;
            post_cnt_d = '0;
            trig_d     = '0;
        end else if (arm) begin
            pre_d      = pre_count;
            post_d     = post_count;
            post_cnt_d = '0;
            trig_d     = '0;
            state_d    = (pre_count == '0) ? StArmed : StPre;
        end else if (wr_en) begin
            unique case (state_q)
                StPre: begin
                    if (fill_inc == {1'b0, pre_q}) state_d = StArmed;
                end
                StArmed: begin
                    if (trigger_hit) begin
                        trig_d  = wr_ptr;
                        state_d = (post_q == '0) ? StDone : StPost;
                    end
                end
                StPost: begin
                    post_cnt_d = post_cnt_inc[BUFFER_W-1:0];
                    if (post_cnt_inc == {1'b0, post_q}) state_d = StDone;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            pre_q      <= '0;
            post_q     <= '0;
            post_cnt_q <= '0;
            trig_q     <= '0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            post_q     <= post_d;
            post_cnt_q <= post_cnt_d;
            trig_q     <= trig_d;
        end
    end

    assign wr_addr      = wr_ptr;
    assign trigger_addr = trig_q;
    assign samples      = fill;
    assign busy         = capturing;
    assign done         = (state_q == StDone);
    assign state        = state_q;

endmodule

// File: tb/tb_ila_capture_ctrl.sv
// Bench for ila_capture_ctrl: directed scenarios plus random traffic, checked
// against a sample-index model of the capture (DEPTH = 16).
module tb_ila_capture_ctrl;

    localparam int W = 4;
    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         rst, rst_soft, arm, sample_valid, trigger_hit;
    logic [W-1:0] pre_count, post_count;
    logic         wr_en, busy, done;
    logic [W-1:0] wr_addr, trigger_addr, start_addr;
    logic [W:0]   samples;
    logic [2:0]   state;

    ila_capture_ctrl #(
        .BUFFER_W (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rst_soft     (rst_soft),
        .arm          (arm),
        .pre_count    (pre_count),
        .post_count   (post_count),
        .sample_valid (sample_valid),
        .trigger_hit  (trigger_hit),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .trigger_addr (trigger_addr),
        .start_addr   (start_addr),
        .samples      (samples),
        .busy         (busy),
        .done         (done),
        .state        (state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: a capture is a sequence of written samples indexed 0,1,2...
    bit m_active;
    int m_count;   // samples written since arm
    int m_trig;    // index of trigger sample, -1 if none yet
    int m_pre, m_post;

    function automatic bit m_done();
        return m_active && m_trig >= 0 && m_count == m_trig + 1 + m_post;
    endfunction

    function automatic int m_state();
        if (!m_active) return 0;
        if (m_done()) return 4;
        if (m_trig >= 0) return 3;
        if (m_count < m_pre) return 1;
        return 2;
    endfunction

    function automatic int m_samples();
        return (m_count > DEPTH) ? DEPTH : m_count;
    endfunction

    task automatic m_reset();
        m_active = 0;
        m_count  = 0;
        m_trig   = -1;
    endtask

    task automatic m_clock(input bit a, input bit s, input bit v, input bit t);
        if (s) begin
            m_reset();
        end else if (a) begin
            m_active = 1;
            m_count  = 0;
            m_trig   = -1;
            m_pre    = int'(pre_count);
            m_post   = int'(post_count);
        end else if (m_active && !m_done() && v) begin
            if (m_trig < 0 && m_count >= m_pre && t) m_trig = m_count;
            m_count++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input bit a, input bit s, input bit v);
        bit exp_we;
        exp_we = v && m_active && !m_done() && !a && !s && !rst;
        chk("wr_en", 32'(wr_en), 32'(exp_we));
        chk("wr_addr", 32'(wr_addr), 32'(m_count % DEPTH));
        chk("state", 32'(state), 32'(m_state()));
        chk("busy", 32'(busy), 32'(m_state() inside {1, 2, 3}));
        chk("done", 32'(done), 32'(m_done()));
        chk("samples", 32'(samples), 32'(m_samples()));
        chk("start_addr", 32'(start_addr), 32'((m_count - m_samples()) % DEPTH));
        chk("trigger_addr", 32'(trigger_addr), 32'((m_trig < 0) ? 0 : m_trig % DEPTH));
    endtask

    // Inputs are driven 1 time unit after a rising edge and checked mid-cycle.
    task automatic cycle(input bit a, input bit s, input bit v, input bit t);
        arm = a; rst_soft = s; sample_valid = v; trigger_hit = t;
        #3;
        check_outputs(a, s, v);
        @(posedge clk);
        m_clock(a, s, v, t);
        #1;
    endtask

    task automatic do_arm(input int p, input int q);
        pre_count  = W'(p);
        post_count = W'(q);
        cycle(1, 0, 0, 0);
    endtask

    task automatic hard_reset();
        arm = 0; rst_soft = 0; sample_valid = 1; trigger_hit = 0;
        rst = 1;
        #2;
        m_reset();
        check_outputs(0, 0, 1);
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        m_reset();
        m_pre = 0; m_post = 0;
        rst = 1; rst_soft = 0; arm = 0; sample_valid = 0; trigger_hit = 0;
        pre_count = '0; post_count = '0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs(0, 0, 0);
        rst = 0;
        cycle(0, 0, 1, 1);

        // Basic capture: trigger on the 6th sample.
        do_arm(3, 2);
        for (int i = 0; i < 10; i++) cycle(0, 0, 1, m_count == 5);
        chk("basic_trig", 32'(trigger_addr), 32'd5);
        chk("basic_samples", 32'(samples), 32'd8);
        chk("basic_start", 32'(start_addr), 32'd0);
        chk("basic_done", 32'(done), 32'd1);

        // Trigger held from arm must not be taken during PRE.
        do_arm(4, 1);
        for (int i = 0; i < 8; i++) cycle(0, 0, 1, 1);
        chk("pretrig_addr", 32'(trigger_addr), 32'd4);

        // Wrap-around.
        do_arm(2, 3);
        for (int i = 0; i < 26; i++) cycle(0, 0, 1, m_count == 19);
        chk("wrap_trig", 32'(trigger_addr), 32'd3);
        chk("wrap_samples", 32'(samples), 32'd16);
        chk("wrap_start", 32'(start_addr), 32'd7);

        // Zero depths.
        do_arm(0, 0);
        cycle(0, 0, 1, 1);
        chk("zero_done", 32'(done), 32'd1);
        cycle(0, 0, 1, 1);
        chk("zero_samples", 32'(samples), 32'd1);

        // Re-arm in POST, then soft reset together with arm.
        do_arm(1, 5);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, m_count == 1);
        chk("rearm_in_post", 32'(state), 32'd3);
        do_arm(2, 2);
        chk("rearm_addr", 32'(wr_addr), 32'd0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0);
        cycle(1, 1, 1, 1);
        chk("soft_state", 32'(state), 32'd0);
        cycle(0, 0, 1, 1);

        // Gapped samples match the dense basic case.
        do_arm(3, 2);
        for (int i = 0; i < 20; i++) cycle(0, 0, i % 2 == 1, (i % 2 == 1) && m_count == 5);
        chk("gap_trig", 32'(trigger_addr), 32'd5);
        chk("gap_samples", 32'(samples), 32'd8);
        chk("gap_start", 32'(start_addr), 32'd0);

        // Asynchronous reset mid-capture.
        do_arm(2, 2);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0);
        hard_reset();
        cycle(0, 0, 1, 1);

        // Random traffic; config inputs wander freely between arms.
        for (int i = 0; i < 600; i++) begin
            pre_count  = W'($urandom_range(0, 15));
            post_count = W'($urandom_range(0, 15));
            cycle($urandom % 30 == 0, $urandom % 150 == 0, $urandom % 3 != 0,
                  $urandom % 5 == 0);
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
